bus_pipe: RTL and testbench
===========================

// Module: bus_pipe
// PURPOSE
//  Parametrised registered bus slice: STAGES-deep pipeline of WIDTH-bit registers with
//  valid/ready handshake, bubble collapsing, synchronous flush and occupancy count.
//  Replaces fixed 4-bit posedge bus registers between producer/consumer blocks.
//  Gives back-pressure and a defined reset state, which the fixed registers lack.
// PARAMETERS
//  WIDTH      4   data bus width in bits (>=1)
//  STAGES     2   register stages in pipeline (>=1; elaboration error otherwise)
//  RESET_VAL  0   WIDTH-bit value loaded into every data register on rst
// PORTS
//  clk        in   1                 rising-edge clock
//  rst        in   1                 asynchronous reset, active high
//  in_valid   in   1                 upstream word available
//  in_ready   out  1                 pipeline accepts in_data this cycle
//  in_data    in   WIDTH             upstream word
//  out_valid  out  1                 stage STAGES-1 holds a word
//  out_ready  in   1                 downstream takes out_data this cycle
//  out_data   out  WIDTH             stage STAGES-1 data register
//  flush      in   1                 synchronous discard of all held words
//  occupancy  out  $clog2(STAGES+1)  number of valid stages
// BEHAVIOUR
//  - Reset (async, rst=1): all stage valid bits 0, all data regs = RESET_VAL, occupancy 0.
//    Combinational outputs during reset: out_valid=0, in_ready=1, out_data=RESET_VAL.
//    Reset mid-transfer drops every held word; no partial output.
//  - Stage i holds (v[i], d[i]); stage 0 fed by in_*, stage STAGES-1 drives out_*.
//  - Stage advance: rdy[STAGES-1] = out_ready; rdy[i] = rdy[i+1] | ~v[i+1];
//    stage i loads from i-1 (or in_*) when ~v[i] | rdy[i].
//    in_ready = (~v[0] | rdy[0]) & ~flush. Ready chain is combinational; no skid.
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Bubbles collapse: an empty stage accepts from upstream even when downstream stalls.
//  - Latency: word accepted at edge N appears on out_data after edge N+STAGES-1
//    when the pipe is empty and never stalled. Throughput 1 word/cycle under out_ready=1.
//  - d[i] updates only on load; while stalled, out_data is held stable.
//  - Order preserved; no word duplicated or lost except by flush/rst.
//  - flush=1: out_valid forced 0 and in_ready forced 0 that cycle.
//    Next edge: all v[i]=0, occupancy=0. Data regs keep their value.
//    Simultaneous in_valid is ignored. flush has priority over any transfer.
//  - occupancy register = popcount(v) after each edge; range 0..STAGES, never wraps.
//    Full: occupancy==STAGES and out_ready=0 -> in_ready=0.
//    Full: occupancy==STAGES and out_ready=1 -> in_ready=1; simultaneous in/out,
//    occupancy unchanged.
//  - Empty: occupancy==0 -> out_valid=0, in_ready=1 (unless flush).
//  - X on in_data with in_valid=0 must not propagate into any valid stage.
// STRUCTURE
//  - Shared package bus_pkg: localparam function clog2-style occupancy width helper;
//    typedef-free (plain Verilog params) so both implementation and bench import it.
//  - One sub-module bus_pipe_stage (WIDTH, RESET_VAL):
//    ports clk, rst, flush, up_valid, up_data, dn_ready, v, d, load.
//    bus_pipe generates STAGES instances plus the occupancy counter.
// TESTING
//  1 Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, occupancy=0,
//    out_data=RESET_VAL, in_ready=1.
//  2 Streaming, WIDTH=4 STAGES=2, out_ready=1: in_data 1,2,3,4 on consecutive cycles
//    -> out_data 1,2,3,4 on consecutive cycles, first one edge after acceptance.
//  3 Back-pressure: fill with A,B (out_ready=0) -> occupancy=2, in_ready=0, out_data=A
//    held. Then out_ready=1 with in_data=C -> outputs A,B,C in order; occupancy stays 2
//    during simultaneous in/out.
//  4 Bubble collapse, STAGES=3: push 5, idle 1 cycle, push 6, out_ready=0
//    -> occupancy reaches 2 with words adjacent; release -> 5 then 6 back-to-back.
//  5 Flush while full with in_valid=1 in_data=F -> in_ready=0 and out_valid=0 that cycle.
//    Next cycle occupancy=0. F never appears at out_data with out_valid=1.
//  6 Async reset mid-stream: assert rst between edges with occupancy=2
//    -> out_valid drops immediately, no edge needed. After release, first output is
//    the next accepted word.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared helpers for the registered bus slice; imported by the RTL and the bench.
package bus_pkg;

    // Bits needed to count 0..stages valid words.
    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/bus_pipe_stage.sv
// One register stage of the bus slice: holds a word and its valid bit, loads when empty or draining.
module bus_pipe_stage #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             load
);

    assign load = ~v | dn_ready;

    // Data only moves with a valid word, so idle garbage on up_data never lands here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (flush) begin
            v <= 1'b0;
        end else if (load) begin
            v <= up_valid;
            if (up_valid) begin
                d <= up_data;
            end
        end
    end

endmodule

// File: rtl/bus_pipe.sv
// STAGES-deep valid/ready register slice with bubble collapsing, synchronous flush and occupancy count.
module bus_pipe
    import bus_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    input  logic                           flush,
    output logic [occ_width(STAGES)-1:0]   occupancy
);

    localparam int unsigned OCC_W = occ_width(STAGES);

    if (STAGES == 0) begin : g_bad_stages
        $error("bus_pipe: STAGES must be at least 1");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] dn_rdy;
    logic [STAGES-1:0] up_v;
    logic [WIDTH-1:0]  up_d [STAGES];
    logic [WIDTH-1:0]  d    [STAGES];
    logic              in_xfer;
    logic              out_xfer;

    // Stage i drains when stage i+1 can load; the last stage drains on out_ready.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up_v[i] = in_valid;
            assign up_d[i] = in_data;
        end else begin : g_body
            assign up_v[i] = v[i-1];
            assign up_d[i] = d[i-1];
        end

        if (i == STAGES - 1) begin : g_tail
            assign dn_rdy[i] = out_ready;
        end else begin : g_link
            assign dn_rdy[i] = load[i+1];
        end

        bus_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (up_v[i]),
            .up_data  (up_d[i]),
            .dn_ready (dn_rdy[i]),
            .v        (v[i]),
            .d        (d[i]),
            .load     (load[i])
        );
    end

    assign in_ready  = load[0] & ~flush;
    assign out_valid = v[STAGES-1] & ~flush;
    assign out_data  = d[STAGES-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Words only enter at stage 0 and leave at the tail, so a +/-1 counter tracks popcount(v).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_bus_pipe.sv
// Bench for bus_pipe: a 2-stage and a 3-stage slice share stimulus and are checked against a word-position model.
module tb_bus_pipe;
    import bus_pkg::*;

    localparam int unsigned      W  = 4;
    localparam logic [W-1:0]     RV = 4'h5;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         flush     = 1'b0;
    logic [W-1:0] in_data   = '0;

    logic                      in_ready2, out_valid2;
    logic [W-1:0]              out_data2;
    logic [occ_width(2)-1:0]   occ2;
    logic                      in_ready3, out_valid3;
    logic [W-1:0]              out_data3;
    logic [occ_width(3)-1:0]   occ3;

    always #5 clk = ~clk;

    bus_pipe #(.WIDTH(W), .STAGES(2), .RESET_VAL(RV)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .flush(flush), .occupancy(occ2)
    );

    bus_pipe #(.WIDTH(W), .STAGES(3), .RESET_VAL(RV)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .flush(flush), .occupancy(occ3)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model k (depth k+2): words oldest first, each with its slot position and data.
    int           mn    [2];
    int           mp    [2][4];
    logic [W-1:0] md    [2][4];
    logic [W-1:0] mlast [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mn[k]    = 0;
            mlast[k] = RV;
        end
    endtask

    // Slot index still free at the back after every word advances as far as it can.
    function automatic int free_lim(input int k, input logic ordy);
        int s   = k + 2;
        int lim = s - 1;
        for (int j = 0; j < mn[k]; j++) begin
            if (j == 0 && mp[k][0] == s - 1 && ordy) continue;
            lim = ((mp[k][j] + 1 < lim) ? mp[k][j] + 1 : lim) - 1;
        end
        return lim;
    endfunction

    function automatic logic exp_in_ready(input int k);
        return !flush && free_lim(k, out_ready) >= 0;
    endfunction

    function automatic logic exp_out_valid(input int k);
        return !flush && mn[k] > 0 && mp[k][0] == k + 1;
    endfunction

    task automatic model_edge(input int k, input logic iv, input logic [W-1:0] id,
                              input logic ordy, input logic fl);
        int           s   = k + 2;
        int           lim = s - 1;
        int           nn  = 0;
        int           np [4];
        logic [W-1:0] nd [4];
        if (fl) begin
            mn[k] = 0;
            return;
        end
        for (int j = 0; j < mn[k]; j++) begin
            int p;
            if (j == 0 && mp[k][0] == s - 1 && ordy) continue;
            p = (mp[k][j] + 1 < lim) ? mp[k][j] + 1 : lim;
            if (p == s - 1 && mp[k][j] != s - 1) mlast[k] = md[k][j];
            np[nn] = p;
            nd[nn] = md[k][j];
            nn++;
            lim = p - 1;
        end
        if (iv && lim >= 0) begin
            np[nn] = 0;
            nd[nn] = id;
            nn++;
        end
        for (int j = 0; j < nn; j++) begin
            mp[k][j] = np[j];
            md[k][j] = nd[j];
        end
        mn[k] = nn;
    endtask

    task automatic check_outputs();
        chk("in_ready2",  32'(in_ready2),  32'(exp_in_ready(0)));
        chk("out_valid2", 32'(out_valid2), 32'(exp_out_valid(0)));
        chk("out_data2",  32'(out_data2),  32'(mlast[0]));
        chk("occ2",       32'(occ2),       32'(mn[0]));
        chk("in_ready3",  32'(in_ready3),  32'(exp_in_ready(1)));
        chk("out_valid3", 32'(out_valid3), 32'(exp_out_valid(1)));
        chk("out_data3",  32'(out_data3),  32'(mlast[1]));
        chk("occ3",       32'(occ3),       32'(mn[1]));
    endtask

    // One clock: drive inputs, check on the falling edge, advance the model on the rising edge.
    task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst) model_reset();
        else for (int k = 0; k < 2; k++) model_edge(k, iv, id, ordy, fl);
        #1;
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;

        // Reset held two cycles with a word offered.
        step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        rst = 1'b0;

        // Streaming at full rate.
        step(1'b1, 4'h1, 1'b1, 1'b0);
        step(1'b1, 4'h2, 1'b1, 1'b0);
        step(1'b1, 4'h3, 1'b1, 1'b0);
        step(1'b1, 4'h4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

        // Back-pressure: fill with A,B then stream C through a full pipe.
        step(1'b0, 4'h0, 1'b1, 1'b1);
        step(1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b1, 4'hB, 1'b0, 1'b0);
        chk("bp_occ2",       32'(occ2),       32'd2);
        chk("bp_in_ready2",  32'(in_ready2),  32'd0);
        chk("bp_out_valid2", 32'(out_valid2), 32'd1);
        chk("bp_out_data2",  32'(out_data2),  32'hA);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'hC, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

        // Bubble collapse: 5, gap, 6, then stall and release.
        step(1'b1, 4'h5, 1'b1, 1'b0);
        step(1'b0, 4'hE, 1'b1, 1'b0);
        step(1'b1, 4'h6, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("bub_occ3", 32'(occ3), 32'd2);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

        // Flush a full pipe while F is offered.
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 7), 1'b0, 1'b0);
        step(1'b1, 4'hF, 1'b0, 1'b1);
        chk("fl_occ2", 32'(occ2), 32'd0);
        chk("fl_occ3", 32'(occ3), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two words held.
        step(1'b1, 4'h3, 1'b0, 1'b0);
        step(1'b1, 4'h4, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid2", 32'(out_valid2), 32'd0);
        chk("ar_out_valid3", 32'(out_valid3), 32'd0);
        chk("ar_occ2",       32'(occ2),       32'd0);
        chk("ar_out_data2",  32'(out_data2),  32'(RV));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 4'hD, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

        // Randomized traffic with stalls and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
